// File: rtl/pgm_arb_pkg.sv
// rtl/pgm_arb_pkg.sv - shared types, defaults and helpers for the DDRAM read arbiter
//
// Contents:
//   arb_state_e  : arbiter FSM states (ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE)
//   DEF_ADDR_W   : default DDRAM word address width
//   DEF_DATA_W   : default DDRAM data width
//   DEF_BE_W     : default byte-enable width
//   BE_ALL       : all-ones byte enable for the default data width
//   rr_next      : wrapping channel index helper used by the round-robin picker

package pgm_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  localparam int DEF_ADDR_W = 29;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_BE_W   = DEF_DATA_W / 8;

  localparam logic [DEF_BE_W-1:0] BE_ALL = '1;

  // Channel that sits 'step' places after 'last', wrapping at n.
  function automatic int rr_next(input int last, input int step, input int n);
    return (last + step) % n;
  endfunction

endpackage

// File: rtl/pgm_rr_picker.sv
// rtl/pgm_rr_picker.sv - combinational fixed-priority / round-robin winner selection
//
// Ports:
//   req_i    in  NUM_CH  pending requests (already masked by the caller)
//   rr_mode_i in 1       0 = lowest index wins, 1 = first requester after last_i
//   last_i   in  3       index of the most recently completed grant
//   win_o    out 3       winning channel index (0 when nothing is pending)
//   valid_o  out 1       at least one request pending

module pgm_rr_picker
  import pgm_arb_pkg::*;
#(
  parameter int NUM_CH = 3
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic              rr_mode_i,
  input  logic [2:0]        last_i,
  output logic [2:0]        win_o,
  output logic              valid_o
);

  logic [NUM_CH-1:0] req_sh;

  // Both searches run from the far end towards the preferred end so the
  // last hit (the most preferred channel) is the one that sticks.
  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    req_sh  = '0;
    if (!rr_mode_i) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        req_sh = req_i >> i;
        if (req_sh[0]) begin
          win_o   = 3'(i);
          valid_o = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        req_sh = req_i >> rr_next(int'(last_i), k, NUM_CH);
        if (req_sh[0]) begin
          win_o   = 3'(rr_next(int'(last_i), k, NUM_CH));
          valid_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pgm_ddram_arb.sv
// rtl/pgm_ddram_arb.sv - N-channel DDRAM read arbiter with loader write passthrough
//
// Optional feature macro: PGM_ARB_TIMEOUT_EN (ISSUE/WAIT watchdog, drives ch_err)
//
// Ports:
//   fixed_50m_clk    in   arbiter / DDRAM clock
//   reset_n          in   synchronous active-low reset
//   rr_mode          in   0 = fixed priority, 1 = round robin (used at IDLE arbitration)
//   loader_active    in   download in progress; aborts reads, passes loader to DDRAM
//   loader_we/addr/din/be in  loader write port
//   ch_req           in   per-channel level request (4-phase)
//   ch_addr          in   per-channel word address, ch i at [i*ADDR_W +: ADDR_W]
//   ch_ack           out  per-channel level acknowledge
//   ch_err           out  per-channel timeout flag, valid with ch_ack
//   ch_data          out  read data of last completed transaction
//   grant_id         out  current / last granted channel
//   ddram_rd/we/addr/din/be out DDRAM command port
//   ddram_dout/busy/dout_ready in DDRAM response port

module pgm_ddram_arb
  import pgm_arb_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 1024,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic                     fixed_50m_clk,
  input  logic                     reset_n,
  input  logic                     rr_mode,
  input  logic                     loader_active,
  input  logic                     loader_we,
  input  logic [ADDR_W-1:0]        loader_addr,
  input  logic [DATA_W-1:0]        loader_din,
  input  logic [BE_W-1:0]          loader_be,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [NUM_CH-1:0]        ch_err,
  output logic [DATA_W-1:0]        ch_data,
  output logic [2:0]               grant_id,
  output logic                     ddram_rd,
  output logic                     ddram_we,
  output logic [ADDR_W-1:0]        ddram_addr,
  output logic [DATA_W-1:0]        ddram_din,
  output logic [BE_W-1:0]          ddram_be,
  input  logic [DATA_W-1:0]        ddram_dout,
  input  logic                     ddram_busy,
  input  logic                     ddram_dout_ready
);

  arb_state_e        state_q;
  logic [2:0]        grant_q;
  logic [2:0]        last_q;
  logic [NUM_CH-1:0] gnt_oh_q;
  logic [NUM_CH-1:0] ack_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              rd_q;

  logic [NUM_CH-1:0] pend;
  logic [2:0]        win;
  logic              win_valid;
  logic [NUM_CH-1:0] win_oh;
  logic [ADDR_W-1:0] sel_addr;
  logic              done_rel;
  logic              timeout_hit;

  // A channel already holding ack is still mid-handshake and must not win again.
  assign pend   = ch_req & ~ack_q;
  assign win_oh = NUM_CH'(1) << win;

  // Granted requester has dropped its request: handshake complete.
  assign done_rel = (state_q == ARB_DONE) && ((ch_req & gnt_oh_q) == '0);

  pgm_rr_picker #(
    .NUM_CH (NUM_CH)
  ) u_picker (
    .req_i     (pend),
    .rr_mode_i (rr_mode),
    .last_i    (last_q),
    .win_o     (win),
    .valid_o   (win_valid)
  );

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win == 3'(i)) sel_addr = ch_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge fixed_50m_clk) begin
    if (!reset_n) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      last_q   <= 3'(NUM_CH - 1);
      gnt_oh_q <= '0;
      ack_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rd_q     <= 1'b0;
    end else if (loader_active) begin
      // Abort whatever is in flight; the requester keeps its request and is
      // served again once the download finishes.
      state_q <= ARB_IDLE;
      ack_q   <= '0;
      rd_q    <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (win_valid) begin
            state_q  <= ARB_ISSUE;
            grant_q  <= win;
            gnt_oh_q <= win_oh;
            addr_q   <= sel_addr;
            rd_q     <= 1'b1;
          end
        end
        ARB_ISSUE: begin
          if (timeout_hit) begin
            state_q <= ARB_DONE;
            data_q  <= '1;
            ack_q   <= gnt_oh_q;
            rd_q    <= 1'b0;
          end else if (!ddram_busy) begin
            state_q <= ARB_WAIT;
            rd_q    <= 1'b0;
          end
        end
        ARB_WAIT: begin
          if (timeout_hit) begin
            state_q <= ARB_DONE;
            data_q  <= '1;
            ack_q   <= gnt_oh_q;
          end else if (ddram_dout_ready) begin
            state_q <= ARB_DONE;
            data_q  <= ddram_dout;
            ack_q   <= gnt_oh_q;
          end
        end
        ARB_DONE: begin
          if (done_rel) begin
            state_q <= ARB_IDLE;
            ack_q   <= '0;
            last_q  <= grant_q;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

`ifdef PGM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0]  cnt_q;
  logic [NUM_CH-1:0] err_q;
  logic              busy_st;

  assign busy_st     = (state_q == ARB_ISSUE) || (state_q == ARB_WAIT);
  assign timeout_hit = busy_st && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge fixed_50m_clk) begin
    if (!reset_n || loader_active) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      if (state_q == ARB_IDLE) begin
        cnt_q <= '0;
      end else if (busy_st && !timeout_hit) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (timeout_hit) begin
        err_q <= gnt_oh_q;
      end else if (done_rel) begin
        err_q <= '0;
      end
    end
  end

  assign ch_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign ch_err      = '0;

  // Watchdog limit only matters when the watchdog is built in.
  if (TIMEOUT_CYC < 1) begin : g_timeout_cfg_unused
  end
`endif

  assign ch_ack   = ack_q;
  assign ch_data  = data_q;
  assign grant_id = grant_q;

  // Loader port bypasses the FSM combinationally so download timing is
  // dictated purely by the loader.
  assign ddram_rd   = loader_active ? 1'b0 : rd_q;
  assign ddram_we   = loader_active ? loader_we : 1'b0;
  assign ddram_addr = loader_active ? loader_addr : addr_q;
  assign ddram_din  = loader_active ? loader_din : '0;
  assign ddram_be   = loader_active ? loader_be : (rd_q ? {BE_W{1'b1}} : '0);

endmodule
